// File: rtl/rv_pkg.sv
// Shared constants and types for the register-file write-back path.
//   XLEN         width of write-back data
//   NREGS        number of architectural registers
//   REG_ADDR_W   register index width
//   STARVE_LIMIT refusals of port 1 before it is given priority for one grant
package rv_pkg;

    localparam int XLEN         = 32;
    localparam int NREGS        = 32;
    localparam int REG_ADDR_W   = $clog2(NREGS);
    localparam int STARVE_LIMIT = 4;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard.
// Tracks registers that have an outstanding producer and flags issue hazards.
//   clk, rst_n    clock, async active-low reset
//   clr_valid     a write-back grant happens this cycle
//   clr_rd        destination of that grant
//   iss_valid     decode wants to issue
//   iss_rs1/rs2   sources of the issuing instruction
//   iss_rd        destination of the issuing instruction
//   iss_wr        issuing instruction writes iss_rd
//   iss_stall     issue must not proceed (combinational, from registered busy only)
module rf_scoreboard
    import rv_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr_valid,
    input  reg_addr_t clr_rd,
    input  logic      iss_valid,
    input  reg_addr_t iss_rs1,
    input  reg_addr_t iss_rs2,
    input  reg_addr_t iss_rd,
    input  logic      iss_wr,
    output logic      iss_stall
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             set_valid;

    always_comb begin
        // No bypass of a same-cycle clear: a register granted this cycle still stalls.
        iss_stall = iss_valid &&
                    (busy_q[iss_rs1] || busy_q[iss_rs2] || (iss_wr && busy_q[iss_rd]));
        set_valid = iss_valid && iss_wr && !iss_stall && (iss_rd != '0);

        busy_d = busy_q;
        if (clr_valid) begin
            busy_d[clr_rd] = 1'b0;
        end
        // Set applied after clear: a new producer outweighs the retiring one.
        if (set_valid) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler sharing the register file's single write port between
// port 0 (single-cycle ALU results, normally preferred) and port 1 (load /
// multi-cycle unit, promoted after repeated refusals). Registers the winning
// write toward the register file and keeps the hazard scoreboard.
//   clk, rst_n                 clock, async active-low reset
//   wb0_valid/rd/data, ready   port 0 request and grant
//   wb1_valid/rd/data, ready   port 1 request and grant
//   iss_valid/rs1/rs2/rd/wr    issuing instruction from decode
//   iss_stall                  hazard against a pending write
//   rf_wen/rf_addr/rf_data     registered register-file write port
module rf_wb_scheduler
    import rv_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wb0_valid,
    input  reg_addr_t wb0_rd,
    input  xlen_t     wb0_data,
    output logic      wb0_ready,
    input  logic      wb1_valid,
    input  reg_addr_t wb1_rd,
    input  xlen_t     wb1_data,
    output logic      wb1_ready,
    input  logic      iss_valid,
    input  reg_addr_t iss_rs1,
    input  reg_addr_t iss_rs2,
    input  reg_addr_t iss_rd,
    input  logic      iss_wr,
    output logic      iss_stall,
    output logic      rf_wen,
    output reg_addr_t rf_addr,
    output xlen_t     rf_data
);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                rf_wen_q, rf_wen_d;
    reg_addr_t           rf_addr_q, rf_addr_d;
    xlen_t               rf_data_q, rf_data_d;

    logic      wb1_pri;
    logic      gnt_valid;
    reg_addr_t gnt_rd;
    xlen_t     gnt_data;

    always_comb begin
        wb1_pri   = wb1_valid && (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
        wb0_ready = wb0_valid && !wb1_pri;
        wb1_ready = wb1_valid && !wb0_ready;
        gnt_valid = wb0_ready || wb1_ready;
        gnt_rd    = wb1_ready ? wb1_rd   : wb0_rd;
        gnt_data  = wb1_ready ? wb1_data : wb0_data;

        starve_cnt_d = '0;
        if (wb1_valid && !wb1_ready) begin
            starve_cnt_d = (starve_cnt_q == STARVE_W'(STARVE_LIMIT))
                         ? starve_cnt_q
                         : starve_cnt_q + STARVE_W'(1);
        end

        // x0 grants are consumed but never reach the register file.
        rf_wen_d  = gnt_valid && (gnt_rd != '0);
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (gnt_valid) begin
            rf_addr_d = gnt_rd;
            rf_data_d = gnt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            rf_wen_q     <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_wen_q     <= rf_wen_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
        end
    end

    assign rf_wen  = rf_wen_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_valid (gnt_valid),
        .clr_rd    (gnt_rd),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_wr    (iss_wr),
        .iss_stall (iss_stall)
    );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready;
    logic        iss_valid, iss_wr;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_stall;
    logic        rf_wen;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit          m_busy [32];
    int          m_starve;
    bit          e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          last_win;

    rf_wb_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb0_valid (wb0_valid),
        .wb0_rd    (wb0_rd),
        .wb0_data  (wb0_data),
        .wb0_ready (wb0_ready),
        .wb1_valid (wb1_valid),
        .wb1_rd    (wb1_rd),
        .wb1_data  (wb1_data),
        .wb1_ready (wb1_ready),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_wr    (iss_wr),
        .iss_stall (iss_stall),
        .rf_wen    (rf_wen),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic idle();
        wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
        wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_wr = 0;
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_starve = 0;
        e_wen    = 0;
        last_win = -1;
    endtask

    // One clock: check combinational outputs against the model mid-cycle,
    // advance the model, then check the registered write just after the edge.
    task automatic cycle();
        int          win;
        bit          e_stall;
        logic [4:0]  grd;
        logic [31:0] gdat;
        @(negedge clk);
        win = -1;
        if (wb1_valid && (m_starve == LIMIT || !wb0_valid)) win = 1;
        else if (wb0_valid)                                  win = 0;
        e_stall = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || (iss_wr && m_busy[iss_rd]));
        chk("wb0_ready", wb0_ready, win == 0);
        chk("wb1_ready", wb1_ready, win == 1);
        chk("iss_stall", iss_stall, e_stall);

        e_wen = 0;
        if (win >= 0) begin
            grd  = (win == 1) ? wb1_rd   : wb0_rd;
            gdat = (win == 1) ? wb1_data : wb0_data;
            m_busy[grd] = 0;
            if (grd != 0) begin
                e_wen  = 1;
                e_addr = grd;
                e_data = gdat;
            end
        end
        if (iss_valid && iss_wr && !e_stall && iss_rd != 0) m_busy[iss_rd] = 1;
        m_busy[0] = 0;
        if (!wb1_valid || win == 1) m_starve = 0;
        else if (m_starve < LIMIT)  m_starve++;
        last_win = win;

        @(posedge clk); #1;
        chk("rf_wen", rf_wen, e_wen);
        if (e_wen) begin
            chk("rf_addr", rf_addr, e_addr);
            chk("rf_data", rf_data, e_data);
        end
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen",  rf_wen,  0);
        chk("rst_addr", rf_addr, 0);
        chk("rst_data", rf_data, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // Reset asserted while a grant is in flight
        iss_valid = 1; iss_wr = 1; iss_rd = 6;
        cycle();
        idle();
        wb0_valid = 1; wb0_rd = 5; wb0_data = 32'h0000_0055;
        cycle();
        #2 rst_n = 0;
        #1;
        chk("t1_wen_async", rf_wen, 0);
        chk("t1_addr_async", rf_addr, 0);
        idle();
        model_reset();
        @(posedge clk); #1;
        chk("t1_wen_held", rf_wen, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        iss_valid = 1; iss_rs1 = 6; iss_rs2 = 5;
        #1 chk("t1_busy_cleared", iss_stall, 0);
        cycle();

        // Single port-0 write
        idle();
        wb0_valid = 1; wb0_rd = 3; wb0_data = 32'hDEAD_BEEF;
        #1 chk("t2_ready", wb0_ready, 1);
        cycle();
        chk("t2_wen",  rf_wen, 1);
        chk("t2_addr", rf_addr, 3);
        chk("t2_data", rf_data, 32'hDEAD_BEEF);
        idle();
        cycle();

        // Continuous contention: port 1 wins on the fifth cycle, then counter restarts
        wb0_valid = 1; wb0_rd = 10; wb0_data = 32'h1000_0000;
        wb1_valid = 1; wb1_rd = 11; wb1_data = 32'h2000_0000;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t3_winner", last_win, (i == 4) ? 1 : 0);
            if (last_win == 0) wb0_data = wb0_data + 1;
            else               wb1_data = wb1_data + 1;
        end
        idle();
        cycle();

        // RAW stall until the cycle after the producer's grant
        iss_valid = 1; iss_wr = 1; iss_rd = 7;
        cycle();
        idle();
        iss_valid = 1; iss_rs1 = 7;
        #1 chk("t4_stall_pending", iss_stall, 1);
        cycle();
        cycle();
        wb0_valid = 1; wb0_rd = 7; wb0_data = 32'h7777_7777;
        #1 chk("t4_stall_grant_cycle", iss_stall, 1);
        cycle();
        wb0_valid = 0;
        #1 chk("t4_free_after", iss_stall, 0);
        cycle();

        // Same-cycle grant and new producer of r9: the register stays busy
        idle();
        wb0_valid = 1; wb0_rd = 9; wb0_data = 32'h9999_0000;
        iss_valid = 1; iss_wr = 1; iss_rd = 9;
        cycle();
        idle();
        iss_valid = 1; iss_rs2 = 9;
        #1 chk("t5_rs2_stall", iss_stall, 1);
        cycle();

        // x0: grant consumed without a write, issue to x0 never busies anything
        idle();
        wb0_valid = 1; wb0_rd = 0; wb0_data = 32'h1;
        iss_valid = 1; iss_wr = 1; iss_rd = 0;
        cycle();
        chk("t6_wen", rf_wen, 0);
        idle();
        iss_valid = 1; iss_wr = 1; iss_rd = 0;
        #1 chk("t6_no_stall", iss_stall, 0);
        cycle();

        // Randomized traffic; requesters hold until granted
        idle();
        for (int n = 0; n < 400; n++) begin
            if (!wb0_valid) begin
                wb0_valid = ($urandom_range(0, 3) != 0);
                wb0_rd    = 5'($urandom_range(0, 15));
                wb0_data  = $urandom;
            end
            if (!wb1_valid) begin
                wb1_valid = ($urandom_range(0, 1) != 0);
                wb1_rd    = 5'($urandom_range(0, 15));
                wb1_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 1) != 0);
            iss_wr    = ($urandom_range(0, 1) != 0);
            iss_rs1   = 5'($urandom_range(0, 15));
            iss_rs2   = 5'($urandom_range(0, 15));
            iss_rd    = 5'($urandom_range(0, 15));
            cycle();
            if (last_win == 0) wb0_valid = 0;
            if (last_win == 1) wb1_valid = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
